// File: rtl/bus_wrr_scheduler_if.sv
// Bundles the per-driver FIFO handshake and the shared packet bus.
// master is the scheduler side; slave is the FIFO/bus side.
interface bus_wrr_scheduler_if #(
  parameter int drvrs   = 4,
  parameter int pckg_sz = 16
);
  logic [drvrs-1:0]         pndng;
  logic [drvrs*pckg_sz-1:0] D_pop;
  logic [drvrs-1:0]         pop;
  logic [drvrs-1:0]         push;
  logic [pckg_sz-1:0]       D_push;
  logic [3:0]               gnt_id;
  logic                     busy;
  logic                     drop;

  modport master (
    input  pndng, D_pop,
    output pop, push, D_push, gnt_id, busy, drop
  );

  modport slave (
    output pndng, D_pop,
    input  pop, push, D_push, gnt_id, busy, drop
  );
endinterface

// File: rtl/bus_wrr_scheduler.sv
// Weighted round-robin scheduler: grants one source FIFO at a time, pops a
// packet, decodes its destination ID and pushes it (or fans it out) on the bus.
module bus_wrr_scheduler #(
  parameter int         drvrs     = 4,
  parameter int         pckg_sz   = 16,
  parameter logic [7:0] broadcast = 8'hFF,
  parameter int         QUANTUM   = 2,
  parameter int         GAP_CYC   = 1
) (
  input logic                 clk,
  input logic                 reset,
  bus_wrr_scheduler_if.master bus
);
  localparam int IDXW = (drvrs > 1) ? $clog2(drvrs) : 1;
  localparam int QW   = $clog2(QUANTUM + 1);
  localparam int GW   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    DLVR = 2'd2,
    GAP  = 2'd3
  } state_e;

  state_e              state_q;
  logic [IDXW-1:0]     gnt_q;
  logic [IDXW-1:0]     last_gnt_q;
  logic [IDXW-1:0]     rr_ptr_q;
  logic                has_gnt_q;
  logic                sel_new_q;
  logic [QW-1:0]       qcnt_q;
  logic [GW-1:0]       gap_q;
  logic [drvrs-1:0]    pop_q;
  logic [drvrs-1:0]    push_q;
  logic [pckg_sz-1:0]  dpush_q;
  logic                busy_q;
  logic                drop_q;

  logic [IDXW-1:0]     sel_idx_d;
  logic                sel_new_d;
  logic [IDXW-1:0]     cand_s;
  logic [pckg_sz-1:0]  pkt_s;
  logic [7:0]          dst_s;
  logic [drvrs-1:0]    mask_d;
  logic                drop_d;

  function automatic logic [drvrs-1:0] onehot(input logic [IDXW-1:0] idx);
    logic [drvrs-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Source selection: keep the current source while its quantum lasts, else search from the RR pointer.
  always_comb begin
    sel_idx_d = last_gnt_q;
    sel_new_d = 1'b0;
    cand_s    = '0;
    if (has_gnt_q && bus.pndng[last_gnt_q] && (qcnt_q < QW'(QUANTUM))) begin
      sel_idx_d = last_gnt_q;
      sel_new_d = 1'b0;
    end else begin
      sel_new_d = 1'b1;
      // Descending scan so the smallest offset from the pointer is written last.
      for (int k = drvrs - 1; k >= 0; k--) begin
        cand_s    = IDXW'((int'(rr_ptr_q) + k) % drvrs);
        sel_idx_d = bus.pndng[cand_s] ? cand_s : sel_idx_d;
      end
    end
  end

  // Destination decode of the granted source's head word.
  always_comb begin
    pkt_s  = bus.D_pop[int'(gnt_q)*pckg_sz +: pckg_sz];
    dst_s  = pkt_s[pckg_sz-1 -: 8];
    mask_d = '0;
    drop_d = 1'b0;
    if (dst_s == broadcast) begin
      mask_d = ~onehot(gnt_q);
    end else if (int'(dst_s) < drvrs) begin
      mask_d = onehot(dst_s[IDXW-1:0]);
    end else begin
      drop_d = 1'b1;
    end
  end

  // Scheduler FSM with registered strobes and bus data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      last_gnt_q <= '0;
      rr_ptr_q   <= '0;
      has_gnt_q  <= 1'b0;
      sel_new_q  <= 1'b0;
      qcnt_q     <= '0;
      gap_q      <= '0;
      pop_q      <= '0;
      push_q     <= '0;
      dpush_q    <= '0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      pop_q   <= '0;
      push_q  <= '0;
      dpush_q <= '0;
      drop_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|bus.pndng) begin
            gnt_q     <= sel_idx_d;
            sel_new_q <= sel_new_d;
            pop_q     <= onehot(sel_idx_d);
            busy_q    <= 1'b1;
            state_q   <= SEL;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        SEL: begin
          if (!bus.pndng[gnt_q]) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            push_q  <= mask_d;
            dpush_q <= pkt_s;
            drop_q  <= drop_d;
            busy_q  <= 1'b1;
            state_q <= DLVR;
          end
        end
        DLVR: begin
          last_gnt_q <= gnt_q;
          has_gnt_q  <= 1'b1;
          rr_ptr_q   <= IDXW'((int'(gnt_q) + 1) % drvrs);
          if (sel_new_q) begin
            qcnt_q <= QW'(1);
          end else if (qcnt_q < QW'(QUANTUM)) begin
            qcnt_q <= qcnt_q + QW'(1);
          end else begin
            qcnt_q <= qcnt_q;
          end
          gap_q <= '0;
          if (GAP_CYC > 0) begin
            busy_q  <= 1'b1;
            state_q <= GAP;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        GAP: begin
          if (gap_q == GW'(GAP_CYC - 1)) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            gap_q   <= gap_q + GW'(1);
            busy_q  <= 1'b1;
            state_q <= GAP;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // A source that drops pndng during SEL sees no pop strobe.
  assign bus.pop    = pop_q & bus.pndng;
  assign bus.push   = push_q;
  assign bus.D_push = dpush_q;
  assign bus.gnt_id = 4'(gnt_q);
  assign bus.busy   = busy_q;
  assign bus.drop   = drop_q;

endmodule
